// File: rtl/tff_using_dff.sv
// rtl/tff_using_dff.sv - bank of WIDTH toggle flip-flops built from a D register plus XOR feedback
// Optional simulation checks are compiled in when TFF_ASSERT_EN is defined.

// D flip-flop stage: WIDTH-bit register with synchronous active-high reset
module tff_dff_stage #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] state_q;

  // Register input is the raw d; reset priority lives in the flop process
  always_comb begin
    state_d = d;
  end

  // Storage: reset wins over any pending d on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_VALUE;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// Toggle flip-flop bank: each bit inverts on an edge where its t bit is high
module tff_using_dff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] reg_q;

  // Next-state logic: XOR with t toggles a bit, zero holds it; bits never interact
  always_comb begin
    next_d = reg_q ^ t;
  end

  tff_dff_stage #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_dff (
    .clk   (clk),
    .reset (reset),
    .d     (next_d),
    .q     (reg_q)
  );

  // Complement is taken straight off the register so it can never lag q
  always_comb begin
    q    = reg_q;
    qbar = ~reg_q;
  end

`ifdef TFF_ASSERT_EN
  // Shadow of the previous edge, used to predict what q must be now
  logic             seen_reset_q;
  logic             prev_reset_q;
  logic [WIDTH-1:0] prev_q_q;
  logic [WIDTH-1:0] prev_t_q;
  logic [WIDTH-1:0] expect_q;

  initial begin
    seen_reset_q = 1'b0;
    prev_reset_q = 1'b0;
    prev_q_q     = '0;
    prev_t_q     = '0;
  end

  // Per-edge checks, active only once a reset edge has been observed
  always @(posedge clk) begin
    if (seen_reset_q || reset === 1'b1) begin
      if ($isunknown(t) || $isunknown(reset)) begin
        $error("tff_using_dff: t or reset unknown at clock edge");
      end
    end
    if (seen_reset_q) begin
      if (qbar !== ~q) begin
        $error("tff_using_dff: qbar %b is not complement of q %b", qbar, q);
      end
      expect_q = prev_reset_q ? RESET_VALUE : (prev_q_q ^ prev_t_q);
      if (q !== expect_q) begin
        $error("tff_using_dff: q %b differs from expected %b", q, expect_q);
      end
    end
    if (reset === 1'b1) begin
      seen_reset_q <= 1'b1;
    end
    prev_reset_q <= (reset === 1'b1);
    prev_q_q     <= q;
    prev_t_q     <= t;
  end
`else
  // No checking logic in this build; behaviour is unchanged
`endif

endmodule

// File: tb/tb_tff_using_dff.sv
// tb/tb_tff_using_dff.sv - table-driven bench for the toggle flip-flop bank
module tb_tff_using_dff;

  logic       clk;
  logic       reset1;
  logic       t1;
  logic       q1;
  logic       qbar1;
  logic       reset4;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qbar4;

  int checks;
  int errors;

  typedef struct {
    logic       reset;
    logic [3:0] t;
    logic [3:0] exp_q;
  } vec_t;

  vec_t v1 [0:13];
  vec_t v4 [0:4];

  tff_using_dff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) dut1 (
    .clk   (clk),
    .reset (reset1),
    .t     (t1),
    .q     (q1),
    .qbar  (qbar1)
  );

  tff_using_dff #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) dut4 (
    .clk   (clk),
    .reset (reset4),
    .t     (t4),
    .q     (q4),
    .qbar  (qbar4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step1(input logic r, input logic tv);
    @(negedge clk);
    reset1 = r;
    t1     = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic r, input logic [3:0] tv);
    @(negedge clk);
    reset4 = r;
    t4     = tv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   rises;
    logic prev;

    checks = 0;
    errors = 0;
    reset1 = 1'b1;
    t1     = 1'b0;
    reset4 = 1'b1;
    t4     = 4'b0000;

    // reset, t, expected q
    v1[0]  = '{1'b1, 4'b0, 4'b0};  // reset with t=0
    v1[1]  = '{1'b1, 4'b1, 4'b0};  // reset with t=1 still clears
    v1[2]  = '{1'b0, 4'b0, 4'b0};  // hold
    v1[3]  = '{1'b0, 4'b0, 4'b0};  // hold
    v1[4]  = '{1'b0, 4'b1, 4'b1};  // toggle sequence 1,1,1,0,0
    v1[5]  = '{1'b0, 4'b1, 4'b0};
    v1[6]  = '{1'b0, 4'b1, 4'b1};
    v1[7]  = '{1'b0, 4'b0, 4'b1};
    v1[8]  = '{1'b0, 4'b0, 4'b1};
    v1[9]  = '{1'b0, 4'b1, 4'b0};  // toggle from 1 -> 0
    v1[10] = '{1'b0, 4'b1, 4'b1};  // q = 1 with t held high
    v1[11] = '{1'b1, 4'b1, 4'b0};  // reset overrides toggle
    v1[12] = '{1'b0, 4'b1, 4'b1};  // release resumes toggling
    v1[13] = '{1'b1, 4'b0, 4'b0};  // reset before free run

    v4[0] = '{1'b1, 4'b1111, 4'b1010};  // reset overrides all toggles
    v4[1] = '{1'b1, 4'b0000, 4'b1010};  // reset held
    v4[2] = '{1'b0, 4'b0110, 4'b1100};  // bits independent
    v4[3] = '{1'b0, 4'b1111, 4'b0011};
    v4[4] = '{1'b0, 4'b0000, 4'b0011};  // hold

    for (int i = 0; i < 14; i++) begin
      step1(v1[i].reset, v1[i].t[0]);
      check($sformatf("w1_q[%0d]", i), {3'b0, q1}, v1[i].exp_q);
      check($sformatf("w1_qbar[%0d]", i), {3'b0, qbar1}, {3'b0, ~v1[i].exp_q[0]});
    end

    // Free-run divide: eight toggling edges give four rising transitions
    rises = 0;
    prev  = q1;
    for (int i = 0; i < 8; i++) begin
      step1(1'b0, 1'b1);
      check($sformatf("freerun_q[%0d]", i), {3'b0, q1}, {3'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
      if (prev == 1'b0 && q1 == 1'b1) rises++;
      prev = q1;
    end
    check("freerun_rises", rises[3:0], 4'd4);
    check("freerun_end", {3'b0, q1}, 4'b0000);

    // Reset held across several edges while t toggles
    for (int i = 0; i < 3; i++) begin
      step1(1'b1, 1'b1);
      check($sformatf("reset_hold_q[%0d]", i), {3'b0, q1}, 4'b0000);
    end

    for (int i = 0; i < 5; i++) begin
      step4(v4[i].reset, v4[i].t);
      check($sformatf("w4_q[%0d]", i), q4, v4[i].exp_q);
      check($sformatf("w4_qbar[%0d]", i), qbar4, ~v4[i].exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
